// File: rtl/vram_blit_ctrl_pkg.sv
// Shared constants, command encodings and FSM states for the VRAM clear/scroll engine.
package vram_blit_ctrl_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 50;
    localparam int unsigned NWORDS = COLS * ROWS;
    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 24;

    // Precomputed address-width constants used by the sequencer.
    localparam logic [AW-1:0] COLS_W    = AW'(COLS);
    localparam logic [AW-1:0] LAST_COL  = AW'(COLS - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(NWORDS - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(NWORDS - COLS);
    localparam logic [AW-1:0] LAST_COPY = AW'(NWORDS - COLS - 1);

    typedef enum logic [1:0] {
        OP_CLEAR       = 2'b00,
        OP_SCROLL_UP   = 2'b01,
        OP_SCROLL_DOWN = 2'b10,
        OP_RSVD        = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COPY_RD = 2'b01,
        COPY_WR = 2'b10,
        FILL_WR = 2'b11
    } state_e;

endpackage

// File: rtl/vram_blit_ctrl_if.sv
// Bus, command and VRAM port-A signals of the clear/scroll engine.
interface vram_blit_ctrl_if;
    import vram_blit_ctrl_pkg::*;

    logic [15:0]   WRADDR;
    logic [3:0]    BYTEEN;
    logic          WREN;
    logic [31:0]   WRDATA;
    logic [15:0]   RDADDR;
    logic          RDEN;
    logic [31:0]   RDDATA;
    logic          START;
    logic [1:0]    OP;
    logic [DW-1:0] FILL;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] VADDR;
    logic [2:0]    VWE;
    logic [DW-1:0] VDIN;
    logic [DW-1:0] VDOUT;

    modport slave (
        input  WRADDR, BYTEEN, WREN, WRDATA, RDADDR, RDEN, START, OP, FILL, VDOUT,
        output RDDATA, BUSY, DONE, VADDR, VWE, VDIN
    );

    modport master (
        output WRADDR, BYTEEN, WREN, WRDATA, RDADDR, RDEN, START, OP, FILL, VDOUT,
        input  RDDATA, BUSY, DONE, VADDR, VWE, VDIN
    );

endinterface

// File: rtl/vram_port_mux.sv
// Port-A arbiter: bus accesses always win, otherwise the engine drives the VRAM port.
module vram_port_mux
    import vram_blit_ctrl_pkg::*;
(
    input  logic          wren,
    input  logic          rden,
    input  logic [15:0]   wraddr,
    input  logic [15:0]   rdaddr,
    input  logic [3:0]    byteen,
    input  logic [31:0]   wrdata,
    input  logic [AW-1:0] eng_addr,
    input  logic [2:0]    eng_we,
    input  logic [DW-1:0] eng_din,
    input  logic [DW-1:0] vdout,
    output logic          bus_act,
    output logic [AW-1:0] vaddr,
    output logic [2:0]    vwe,
    output logic [DW-1:0] vdin,
    output logic [31:0]   rddata
);

    // Byte-address low bits, upper address bits and the top lane are not wired to the VRAM.
    logic unused_bits;
    assign unused_bits = ^{wraddr[15:14], wraddr[1:0], rdaddr[15:14], rdaddr[1:0],
                           byteen[3], wrdata[31:24]};

    // Select the port-A owner for this cycle.
    always_comb begin
        bus_act = wren | rden;
        if (bus_act) begin
            vaddr = rden ? rdaddr[AW+1:2] : wraddr[AW+1:2];
            vwe   = {3{wren}} & byteen[2:0];
            vdin  = wrdata[DW-1:0];
        end else begin
            vaddr = eng_addr;
            vwe   = eng_we;
            vdin  = eng_din;
        end
    end

    assign rddata = {8'h00, vdout};

endmodule

// File: rtl/vram_blit_ctrl.sv
// Clear/scroll sequencer for the 80x50 character VRAM, sharing port A with the bus.
module vram_blit_ctrl
    import vram_blit_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    vram_blit_ctrl_if.slave  bus
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          done_q, done_d;

    logic          bus_act;
    logic [AW-1:0] eng_addr;
    logic [2:0]    eng_we;
    logic [DW-1:0] eng_din;

    logic [AW-1:0] copy_src, copy_dst, fill_addr, fill_last;
    logic          start_ok;

    assign start_ok = bus.START && (state_q == IDLE) && (bus.OP != OP_RSVD);

    // Map the step counter onto source/destination addresses for the latched command.
    always_comb begin
        if (op_q == OP_SCROLL_UP) begin
            copy_src  = cnt_q + COLS_W;
            copy_dst  = cnt_q;
            fill_addr = LAST_ROW + cnt_q;
        end else begin
            copy_src  = LAST_COPY - cnt_q;
            copy_dst  = LAST_WORD - cnt_q;
            fill_addr = cnt_q;
        end
        fill_last = (op_q == OP_CLEAR) ? LAST_WORD : LAST_COL;
    end

    // Next-state and engine port requests; everything holds while the bus owns the port.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        eng_addr = '0;
        eng_we   = 3'b000;
        eng_din  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    op_d    = op_e'(bus.OP);
                    fill_d  = bus.FILL;
                    cnt_d   = '0;
                    state_d = (bus.OP == OP_CLEAR) ? FILL_WR : COPY_RD;
                end
            end
            COPY_RD: begin
                eng_addr = copy_src;
                if (!bus_act) state_d = COPY_WR;
            end
            COPY_WR: begin
                eng_addr = copy_dst;
                eng_we   = 3'b111;
                eng_din  = bus.VDOUT;
                if (bus_act) begin
                    // VDOUT goes stale once the bus reads; reissue the read.
                    state_d = COPY_RD;
                end else if (cnt_q == LAST_COPY) begin
                    cnt_d   = '0;
                    state_d = FILL_WR;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = COPY_RD;
                end
            end
            FILL_WR: begin
                eng_addr = fill_addr;
                eng_we   = 3'b111;
                if (!bus_act) begin
                    if (cnt_q == fill_last) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State, counter and latched-command registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= OP_CLEAR;
            cnt_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    assign bus.BUSY = (state_q != IDLE);
    assign bus.DONE = done_q;

    vram_port_mux u_mux (
        .wren     (bus.WREN),
        .rden     (bus.RDEN),
        .wraddr   (bus.WRADDR),
        .rdaddr   (bus.RDADDR),
        .byteen   (bus.BYTEEN),
        .wrdata   (bus.WRDATA),
        .eng_addr (eng_addr),
        .eng_we   (eng_we),
        .eng_din  (eng_din),
        .vdout    (bus.VDOUT),
        .bus_act  (bus_act),
        .vaddr    (bus.VADDR),
        .vwe      (bus.VWE),
        .vdin     (bus.VDIN),
        .rddata   (bus.RDDATA)
    );

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// Directed bench for vram_blit_ctrl with a behavioural 4096x24 VRAM on port A.
module tb_vram_blit_ctrl;
    import vram_blit_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic pre_req;
    logic [DW-1:0] mem [0:4095];
    int checks = 0;
    int errors = 0;

    vram_blit_ctrl_if bus();

    vram_blit_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM port A: per-lane writes, read-first, 1-cycle read latency; preload writes word n = n.
    always @(posedge clk) begin
        if (pre_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= DW'(i);
        end else begin
            if (bus.VWE[0]) mem[bus.VADDR][7:0]   <= bus.VDIN[7:0];
            if (bus.VWE[1]) mem[bus.VADDR][15:8]  <= bus.VDIN[15:8];
            if (bus.VWE[2]) mem[bus.VADDR][23:16] <= bus.VDIN[23:16];
        end
        bus.VDOUT <= mem[bus.VADDR];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        pre_req = 1'b1;
        tick();
        pre_req = 1'b0;
    endtask

    // kind 0: words below lim hold fill; 1: scrolled up; 2: scrolled down. Others keep n.
    function automatic int count_bad(input int kind, input logic [DW-1:0] fill, input int lim);
        int bad = 0;
        logic [DW-1:0] e;
        for (int i = 0; i < 4096; i++) begin
            if (kind == 0)      e = (i < lim) ? fill : DW'(i);
            else if (kind == 1) e = (i < 3920) ? DW'(i + 80) : ((i < 4000) ? fill : DW'(i));
            else                e = (i < 80) ? fill : ((i < 4000) ? DW'(i - 80) : DW'(i));
            if (mem[i] !== e) bad++;
        end
        return bad;
    endfunction

    // Issue one command, count busy cycles and DONE pulses; optional stray START mid-run.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] fill, input int stray_at,
                           input logic [1:0] stray_op, output int busy_n, output int done_n);
        bus.OP    = op;
        bus.FILL  = fill;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.FILL  = 24'h555555;
        busy_n = 0;
        done_n = 0;
        while (bus.BUSY && busy_n < 20000) begin
            if (busy_n == stray_at) begin
                bus.START = 1'b1;
                bus.OP    = stray_op;
            end else begin
                bus.START = 1'b0;
            end
            busy_n++;
            tick();
            if (bus.DONE) done_n++;
        end
        bus.START = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.DONE) done_n++;
        end
    endtask

    initial begin
        int busy_n;
        int done_n;
        int n;
        int addr;
        logic rd_pend;
        logic [31:0] rd_exp;

        rst        = 1'b1;
        pre_req    = 1'b0;
        bus.WRADDR = '0;
        bus.BYTEEN = '0;
        bus.WREN   = 1'b0;
        bus.WRDATA = '0;
        bus.RDADDR = '0;
        bus.RDEN   = 1'b0;
        bus.START  = 1'b0;
        bus.OP     = '0;
        bus.FILL   = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_vwe", 32'(bus.VWE), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(bus.BUSY), 32'd0);

        // Bus byte-lane write then read back through RDDATA.
        preload();
        bus.WRADDR = 16'h0014;
        bus.BYTEEN = 4'b0101;
        bus.WRDATA = 32'hFFAABBCC;
        bus.WREN   = 1'b1;
        #1;
        check("bus_wr_vaddr", 32'(bus.VADDR), 32'd5);
        check("bus_wr_vwe", 32'(bus.VWE), 32'b101);
        tick();
        bus.WREN   = 1'b0;
        bus.RDADDR = 16'h0014;
        bus.RDEN   = 1'b1;
        tick();
        bus.RDEN   = 1'b0;
        check("bus_rd_data", bus.RDDATA, 32'h00AA00CC);

        // CLEAR with no traffic.
        preload();
        run_cmd(2'b00, 24'h0FFF41, -1, 2'b00, busy_n, done_n);
        check("clear_busy_cycles", 32'(busy_n), 32'd4000);
        check("clear_done_count", 32'(done_n), 32'd1);
        check("clear_word0", 32'(mem[0]), 32'h0FFF41);
        check("clear_word3999", 32'(mem[3999]), 32'h0FFF41);
        check("clear_word4000", 32'(mem[4000]), 32'd4000);
        check("clear_all", 32'(count_bad(0, 24'h0FFF41, 4000)), 32'd0);
        bus.RDADDR = 16'd0;
        bus.RDEN   = 1'b1;
        tick();
        bus.RDEN   = 1'b0;
        check("clear_rd_word0", bus.RDDATA, 32'h000FFF41);

        // SCROLL_UP with no traffic.
        preload();
        run_cmd(2'b01, 24'h000000, -1, 2'b00, busy_n, done_n);
        check("up_busy_cycles", 32'(busy_n), 32'd7920);
        check("up_done_count", 32'(done_n), 32'd1);
        check("up_word0", 32'(mem[0]), 32'd80);
        check("up_word3919", 32'(mem[3919]), 32'd3999);
        check("up_word3920", 32'(mem[3920]), 32'd0);
        check("up_all", 32'(count_bad(1, 24'h000000, 0)), 32'd0);

        // SCROLL_DOWN with no traffic.
        preload();
        run_cmd(2'b10, 24'h0A0B0C, -1, 2'b00, busy_n, done_n);
        check("down_busy_cycles", 32'(busy_n), 32'd7920);
        check("down_done_count", 32'(done_n), 32'd1);
        check("down_word3999", 32'(mem[3999]), 32'd3919);
        check("down_word80", 32'(mem[80]), 32'd0);
        check("down_word0", 32'(mem[0]), 32'h0A0B0C);
        check("down_all", 32'(count_bad(2, 24'h0A0B0C, 0)), 32'd0);

        // SCROLL_UP with a bus read every third cycle.
        preload();
        bus.OP    = 2'b01;
        bus.FILL  = 24'h000000;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        n = 0;
        rd_pend = 1'b0;
        rd_exp = '0;
        while (bus.BUSY && n < 30000) begin
            if (rd_pend) check("traffic_rd", bus.RDDATA, rd_exp);
            rd_pend = (n % 3 == 0);
            addr = (n * 13) % 4000;
            bus.RDEN   = rd_pend;
            bus.RDADDR = 16'(addr * 4);
            rd_exp = {8'h00, mem[addr]};
            n++;
            tick();
        end
        if (rd_pend) check("traffic_rd", bus.RDDATA, rd_exp);
        bus.RDEN = 1'b0;
        check("traffic_done", 32'(bus.DONE), 32'd1);
        check("traffic_busy_ext", 32'(n > 7920 && n < 30000), 32'd1);
        check("traffic_all", 32'(count_bad(1, 24'h000000, 0)), 32'd0);
        tick();

        // CLEAR with a stray SCROLL_UP START mid-run.
        preload();
        run_cmd(2'b00, 24'h000777, 50, 2'b01, busy_n, done_n);
        check("stray_busy_cycles", 32'(busy_n), 32'd4000);
        check("stray_done_count", 32'(done_n), 32'd1);
        check("stray_all", 32'(count_bad(0, 24'h000777, 4000)), 32'd0);

        // Reserved opcode from IDLE is ignored.
        bus.OP    = 2'b11;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("rsvd_busy", 32'(bus.BUSY), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rsvd_done", 32'(bus.DONE), 32'd0);
        end

        // Reset at busy cycle 100 of CLEAR.
        preload();
        bus.OP    = 2'b00;
        bus.FILL  = 24'h00BEEF;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (99) tick();
        check("rstmid_busy_before", 32'(bus.BUSY), 32'd1);
        rst = 1'b1;
        tick();
        check("rstmid_busy", 32'(bus.BUSY), 32'd0);
        check("rstmid_done", 32'(bus.DONE), 32'd0);
        rst = 1'b0;
        tick();
        check("rstmid_done_after", 32'(bus.DONE), 32'd0);
        check("rstmid_word99", 32'(mem[99]), 32'h00BEEF);
        check("rstmid_word100", 32'(mem[100]), 32'd100);
        check("rstmid_all", 32'(count_bad(0, 24'h00BEEF, 100)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
